risc16_bpu: RTL and testbench

RISC16_BPU -- requirements
Module: risc16_bpu

---
 rtl/risc16_pkg.sv | 12 +
 rtl/risc16_bpu_if.sv | 23 ++
 rtl/risc16_sat2.sv | 11 +
 rtl/risc16_bpu.sv | 55 +++++
 tb/tb_risc16_bpu.sv | 135 +++++++++++++
 5 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared types and constants for the branch predictor
package risc16_pkg;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
    localparam logic [15:0] INSN_W = 16'd2;
    // tag is sized for the smallest useful table; unused upper bits stay zero
    typedef struct packed {
        logic        valid;
        logic [14:0] tag;
        logic [15:0] target;
        ctr_t        ctr;
    } entry_t;
endpackage

// File: rtl/risc16_bpu_if.sv
// risc16_bpu_if: fetch lookup and branch-resolution update bus
interface risc16_bpu_if;
    logic [15:0] if_pc;
    logic [15:0] pred_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        upd_uncond;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_pc;
    logic        mispredict;
    logic [15:0] mispredict_cnt;
    modport master (
        output if_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_uncond, upd_pred_taken, upd_pred_pc,
        input  pred_pc, pred_taken, mispredict, mispredict_cnt
    );
    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_uncond, upd_pred_taken, upd_pred_pc,
        output pred_pc, pred_taken, mispredict, mispredict_cnt
    );
endinterface

// File: rtl/risc16_sat2.sv
// risc16_sat2: 2-bit saturating counter next state
module risc16_sat2
    import risc16_pkg::*;
(
    input  ctr_t ctr,
    input  logic inc,
    output ctr_t nxt
);
    always_comb nxt = inc ? (ctr == ST ? ST : ctr_t'(ctr + 2'd1))
                          : (ctr == SNT ? SNT : ctr_t'(ctr - 2'd1));
endmodule

// File: rtl/risc16_bpu.sv
// risc16_bpu: direct-mapped BTB with 2-bit counters and a saturating mispredict counter
module risc16_bpu
    import risc16_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input logic clk,
    input logic rst,
    risc16_bpu_if.slave bus
);
    localparam int N = 1 << IDX_W;
    entry_t tbl [N];
    entry_t re, we, nw;
    logic [IDX_W-1:0] ri, wi;
    logic [14:0] rtag, wtag;
    logic hit, uhit, wr;
    ctr_t sat_nxt;
    logic [15:0] cnt;
    logic unused_pc0;
    assign unused_pc0 = bus.upd_pc[0];
    assign ri = bus.if_pc[IDX_W:1];
    assign wi = bus.upd_pc[IDX_W:1];
    assign rtag = 15'(bus.if_pc >> (IDX_W + 1));
    assign wtag = 15'(bus.upd_pc >> (IDX_W + 1));
    assign re = tbl[ri];
    assign we = tbl[wi];
    assign hit = re.valid && re.tag == rtag;
    assign uhit = we.valid && we.tag == wtag;
    assign bus.pred_taken = hit && re.ctr[1];
    assign bus.pred_pc = bus.pred_taken ? re.target : bus.if_pc + INSN_W;
    assign bus.mispredict = bus.upd_valid && ((bus.upd_taken != bus.upd_pred_taken) ||
                            (bus.upd_taken && bus.upd_target != bus.upd_pred_pc));
    assign bus.mispredict_cnt = cnt;
    risc16_sat2 u_sat (.ctr(we.ctr), .inc(bus.upd_taken), .nxt(sat_nxt));
    // a not-taken conditional branch that misses never allocates
    always_comb begin
        wr = bus.upd_valid && (uhit || bus.upd_taken || bus.upd_uncond);
        nw.valid = 1'b1;
        nw.tag = wtag;
        nw.target = (bus.upd_taken || bus.upd_uncond) ? bus.upd_target : we.target;
        nw.ctr = bus.upd_uncond ? ST : uhit ? sat_nxt : WT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                tbl[i].valid <= 1'b0;
                tbl[i].ctr <= SNT;
            end
            cnt <= '0;
        end else begin
            if (wr) tbl[wi] <= nw;
            if (bus.mispredict && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_risc16_bpu.sv
// tb_risc16_bpu: directed plus random checks against a table-level reference model
module tb_risc16_bpu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    risc16_bpu_if bus ();
    risc16_bpu #(.IDX_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int errors = 0;
    int checks = 0;
    bit m_valid [64];
    int m_tag [64];
    int m_tgt [64];
    int m_ctr [64];
    int m_cnt;

    function automatic int m_pred_pc(input int pc);
        int i = (pc / 2) % 64;
        if (m_valid[i] && m_tag[i] == pc / 128 && m_ctr[i] >= 2) return m_tgt[i];
        return (pc + 2) % 65536;
    endfunction

    function automatic bit m_pred_tk(input int pc);
        int i = (pc / 2) % 64;
        return m_valid[i] && m_tag[i] == pc / 128 && m_ctr[i] >= 2;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit c, input bit r, input int ipc, input bit v, input int pc, input int tgt,
                        input bit tk, input bit un, input bit ptk, input int ppc);
        bit mp;
        int i, t;
        @(negedge clk);
        rst = r;
        bus.if_pc = 16'(ipc);
        bus.upd_valid = v;
        bus.upd_pc = 16'(pc);
        bus.upd_target = 16'(tgt);
        bus.upd_taken = tk;
        bus.upd_uncond = un;
        bus.upd_pred_taken = ptk;
        bus.upd_pred_pc = 16'(ppc);
        mp = v && (tk != ptk || (tk && tgt != ppc));
        #1;
        if (c) begin
            chk("pred_taken", 16'(bus.pred_taken), 16'(m_pred_tk(ipc)));
            chk("pred_pc", bus.pred_pc, 16'(m_pred_pc(ipc)));
            chk("mispredict", 16'(bus.mispredict), 16'(mp));
            chk("mispredict_cnt", bus.mispredict_cnt, 16'(m_cnt));
        end
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 0;
                m_ctr[k] = 0;
            end
            m_cnt = 0;
        end else begin
            if (mp && m_cnt < 65535) m_cnt++;
            i = (pc / 2) % 64;
            t = pc / 128;
            if (v) begin
                if (un) begin
                    m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = tgt; m_ctr[i] = 3;
                end else if (m_valid[i] && m_tag[i] == t) begin
                    m_ctr[i] = tk ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
                    if (tk) m_tgt[i] = tgt;
                end else if (tk) begin
                    m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = tgt; m_ctr[i] = 2;
                end
            end
        end
    endtask

    task automatic look(input int ipc);
        step(1, 0, ipc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input int pc, input int tgt, input bit tk, input bit un, input bit ptk, input int ppc);
        step(1, 0, pc, 1, pc, tgt, tk, un, ptk, ppc);
    endtask

    initial begin
        int pc, tgt, ipc;
        bit tk, un, ptk;
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        look(16'h0010);
        upd(16'h0010, 16'h0040, 1, 0, 0, 16'h0012);
        look(16'h0010);
        look(16'h0090);
        repeat (2) upd(16'h0010, 16'h0040, 0, 0, 1, 16'h0040);
        look(16'h0010);
        repeat (3) upd(16'h0010, 16'h0040, 1, 0, 0, 16'h0012);
        look(16'h0010);
        upd(16'h0010, 16'h0044, 1, 0, 1, 16'h0040);
        upd(16'h0010, 16'h0044, 1, 0, 1, 16'h0044);
        @(negedge clk);
        dut.cnt = 16'hFFFD;
        m_cnt = 65533;
        repeat (3) upd(16'h0010, 16'h0048, 1, 0, 1, 16'h0040);
        look(16'h0010);
        upd(16'h0020, 16'h0100, 0, 1, 0, 16'h0022);
        look(16'h0020);
        look(16'hFFFE);
        step(1, 1, 16'h0030, 1, 16'h0030, 16'h0200, 1, 0, 0, 16'h0032);
        look(16'h0030);
        look(16'h0010);
        look(16'h0020);
        upd(16'h0050, 16'h0060, 1, 0, 0, 16'h0052);
        step(1, 0, 16'h0050, 1, 16'h0050, 16'h0060, 0, 0, 1, 16'h0060);
        look(16'h0050);
        upd(16'h0050, 16'h0070, 1, 0, 0, 16'h0052);
        step(1, 0, 16'h0050, 1, 16'h0050, 16'h0080, 1, 0, 1, 16'h0070);
        look(16'h0050);
        for (int n = 0; n < 400; n++) begin
            pc = int'($urandom_range(0, 3)) * 128 + int'($urandom_range(0, 7)) * 2 + int'($urandom_range(0, 1));
            tgt = int'($urandom_range(0, 3)) * 16'h0100;
            tk = 1'($urandom);
            un = ($urandom_range(0, 7) == 0);
            if (un) tk = 1'($urandom);
            ptk = $urandom_range(0, 3) == 0 ? 1'($urandom) : m_pred_tk(pc);
            ipc = $urandom_range(0, 2) == 0 ? pc : int'($urandom_range(0, 3)) * 128 + int'($urandom_range(0, 7)) * 2;
            step(1, $urandom_range(0, 60) == 0, ipc, 1'($urandom), pc, tgt, tk, un, ptk, m_pred_pc(pc));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
